pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 87 ++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parameterised pipeline register chain with stall/flush control, bubble
// encoding (invalid stages carry zero payload) and saturating event counters.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int CNT_W = 16,
    localparam int OCC_W = ($clog2(DEPTH + 1) > 0) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [DEPTH-1:0]            validQ, validNext;
    logic [DEPTH-1:0][WIDTH-1:0] dataQ, dataNext;
    logic [OCC_W-1:0]            occQ, occNext;
    logic [CNT_W-1:0]            stallCntQ, flushCntQ, bubbleCntQ;

    // Occupancy is counted from the next-state valid vector so the registered
    // value lines up with the stage valid bits on the same edge.
    always_comb begin
        validNext = validQ;
        dataNext  = dataQ;
        if (flush) begin
            validNext = '0;
            dataNext  = '0;
        end else if (!stall) begin
            validNext[0] = in_valid;
            dataNext[0]  = in_valid ? in_data : '0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                validNext[k] = validQ[k-1];
                dataNext[k]  = dataQ[k-1];
            end
        end
        occNext = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occNext = occNext + OCC_W'(validNext[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            validQ <= '0;
            dataQ  <= '0;
            occQ   <= '0;
        end else begin
            validQ <= validNext;
            dataQ  <= dataNext;
            occQ   <= occNext;
        end
    end

    // Flush takes precedence over stall, so a combined request counts only as a flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCntQ  <= '0;
            flushCntQ  <= '0;
            bubbleCntQ <= '0;
        end else begin
            if (flush) begin
                if (flushCntQ != '1) flushCntQ <= flushCntQ + CNT_W'(1);
            end else if (stall) begin
                if (stallCntQ != '1) stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (!validQ[DEPTH-1] && (bubbleCntQ != '1)) begin
                bubbleCntQ <= bubbleCntQ + CNT_W'(1);
            end
        end
    end

    assign out_valid  = validQ[DEPTH-1];
    assign out_data   = dataQ[DEPTH-1];
    assign occupancy  = occQ;
    assign stall_cnt  = stallCntQ;
    assign flush_cnt  = flushCntQ;
    assign bubble_cnt = bubbleCntQ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (DEPTH=3, WIDTH=32, CNT_W=4).
module tb_pipe_stage_reg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CNT_W = 4;
    localparam int OCC_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             inValid;
    logic [WIDTH-1:0] inData;
    logic             stall;
    logic             flush;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] stallCnt, flushCnt, bubbleCnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_data   (inData),
        .stall     (stall),
        .flush     (flush),
        .out_valid (outValid),
        .out_data  (outData),
        .occupancy (occupancy),
        .stall_cnt (stallCnt),
        .flush_cnt (flushCnt),
        .bubble_cnt(bubbleCnt)
    );

    always #5 clk = ~clk;

    // Apply inputs for one edge, then settle 1 time unit past the edge.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d,
                        input logic s, input logic f);
        rst = r; inValid = v; inData = d; stall = s; flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 32'hCAFE, 1'b0, 1'b0);
        do_reset();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", outValid); end
        checks++; if (outData !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", outData); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if ({stallCnt, flushCnt, bubbleCnt} !== 12'h0) begin errors++;
            $display("FAIL reset_cnts got %0d/%0d/%0d exp 0/0/0", stallCnt, flushCnt, bubbleCnt); end
    endtask

    task automatic test_flow();
        do_reset();
        step(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL flow_occ1 got %0d exp 1", occupancy); end
        step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flow_early got %0b exp 0", outValid); end
        step(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h11) begin errors++;
            $display("FAIL flow_out11 got %0b/%0h exp 1/11", outValid, outData); end
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL flow_occ3 got %0d exp 3", occupancy); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h22 || occupancy !== 2'd2) begin errors++;
            $display("FAIL flow_out22 got %0b/%0h/%0d exp 1/22/2", outValid, outData, occupancy); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h33 || occupancy !== 2'd1) begin errors++;
            $display("FAIL flow_out33 got %0b/%0h/%0d exp 1/33/1", outValid, outData, occupancy); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0 || occupancy !== 2'd0) begin errors++;
            $display("FAIL flow_drain got %0b/%0h/%0d exp 0/0/0", outValid, outData, occupancy); end
        checks++; if (bubbleCnt !== 4'd3) begin errors++; $display("FAIL flow_bubble got %0d exp 3", bubbleCnt); end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b1, 1'b1, 32'hA5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
            checks++; if (outValid !== 1'b0 || occupancy !== 2'd1 || stallCnt !== CNT_W'(i)) begin errors++;
                $display("FAIL stall_hold%0d got %0b/%0d/%0d exp 0/1/%0d", i, outValid, occupancy, stallCnt, i); end
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'hA5) begin errors++;
            $display("FAIL stall_out got %0b/%0h exp 1/a5", outValid, outData); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0 || stallCnt !== 4'd2) begin errors++;
            $display("FAIL stall_ignored got %0b/%0h/%0d exp 0/0/2", outValid, outData, stallCnt); end
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h99, 1'b1, 1'b1);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0 || occupancy !== 2'd0) begin errors++;
            $display("FAIL flush_clear got %0b/%0h/%0d exp 0/0/0", outValid, outData, occupancy); end
        checks++; if (flushCnt !== 4'd1 || stallCnt !== 4'd0) begin errors++;
            $display("FAIL flush_cnts got f%0d s%0d exp f1 s0", flushCnt, stallCnt); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || occupancy !== 2'd0) begin errors++;
            $display("FAIL flush_discard got %0b/%0d exp 0/0", outValid, occupancy); end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, 32'hBAD, 1'b1, 1'b0);
            if (i == 15 || i == 20) begin
                checks++; if (stallCnt !== 4'd15) begin errors++;
                    $display("FAIL sat_stall%0d got %0d exp 15", i, stallCnt); end
            end
        end
        checks++; if (bubbleCnt !== 4'd15 || occupancy !== 2'd2) begin errors++;
            $display("FAIL sat_bubble_occ got %0d/%0d exp 15/2", bubbleCnt, occupancy); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h10) begin errors++;
            $display("FAIL sat_resume10 got %0b/%0h exp 1/10", outValid, outData); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h20 || stallCnt !== 4'd15) begin errors++;
            $display("FAIL sat_resume20 got %0b/%0h/%0d exp 1/20/15", outValid, outData, stallCnt); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0) begin errors++;
            $display("FAIL sat_drain got %0b/%0h exp 0/0", outValid, outData); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hA2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hA2, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hB3, 1'b0, 1'b0);
        checks++; if (occupancy !== 2'd3 || outData !== 32'hB1) begin errors++;
            $display("FAIL mid_full got %0d/%0h exp 3/b1", occupancy, outData); end
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0 || occupancy !== 2'd0) begin errors++;
            $display("FAIL mid_clear got %0b/%0h/%0d exp 0/0/0", outValid, outData, occupancy); end
        checks++; if ({stallCnt, flushCnt, bubbleCnt} !== 12'h0) begin errors++;
            $display("FAIL mid_cnts got %0d/%0d/%0d exp 0/0/0", stallCnt, flushCnt, bubbleCnt); end
        step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL mid_early got %0b exp 0", outValid); end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h77) begin errors++;
            $display("FAIL mid_out77 got %0b/%0h exp 1/77", outValid, outData); end
    endtask

    task automatic test_bubble();
        do_reset();
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h42, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0) begin errors++;
            $display("FAIL bubble_slot got %0b/%0h exp 0/0", outValid, outData); end
        checks++; if (bubbleCnt !== 4'd3) begin errors++; $display("FAIL bubble_cnt3 got %0d exp 3", bubbleCnt); end
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b1 || outData !== 32'h42 || bubbleCnt !== 4'd4) begin errors++;
            $display("FAIL bubble_next got %0b/%0h/%0d exp 1/42/4", outValid, outData, bubbleCnt); end
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++; if (outValid !== 1'b0 || outData !== 32'h0 || bubbleCnt !== 4'd4) begin errors++;
            $display("FAIL bubble_hold got %0b/%0h/%0d exp 0/0/4", outValid, outData, bubbleCnt); end
    endtask

    initial begin
        rst = 1'b0; inValid = 1'b0; inData = '0; stall = 1'b0; flush = 1'b0;
        test_reset();
        test_flow();
        test_stall();
        test_flush();
        test_saturate();
        test_reset_mid();
        test_bubble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
